// File: rtl/ysyx_22051013_axi_arb_pkg.sv
// Shared definitions for the AXI4-lite N-to-1 arbiter: response codes,
// FSM state encoding and default bus widths.
package ysyx_22051013_axi_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_RESP
    } arb_state_e;

endpackage

// File: rtl/ysyx_22051013_rr_arb.sv
// Combinational request picker: round-robin from ptr by default, or fixed
// lowest-index priority when YSYX_22051013_AXI_ARB_FIXED_PRIO_EN is defined.
module ysyx_22051013_rr_arb #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_any
);

`ifdef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
`endif
            if (!gnt_any && req[idx]) begin
                gnt_any     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ysyx_22051013_axi_arb.sv
// N-to-1 AXI4-lite arbiter, one transaction in flight, payload latched at grant.
// Define YSYX_22051013_AXI_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ysyx_22051013_axi_arb
    import ysyx_22051013_axi_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] s_ar_addr,
    input  logic [NUM_CH-1:0]        s_ar_valid,
    output logic [NUM_CH-1:0]        s_ar_ready,
    output logic [DATA_W-1:0]        s_r_data,
    output logic [1:0]               s_r_resp,
    output logic [NUM_CH-1:0]        s_r_valid,
    input  logic [NUM_CH-1:0]        s_r_ready,
    input  logic [NUM_CH*ADDR_W-1:0] s_aw_addr,
    input  logic [NUM_CH-1:0]        s_aw_valid,
    output logic [NUM_CH-1:0]        s_aw_ready,
    input  logic [NUM_CH*DATA_W-1:0] s_w_data,
    input  logic [NUM_CH*STRB_W-1:0] s_w_strb,
    input  logic [NUM_CH-1:0]        s_w_valid,
    output logic [NUM_CH-1:0]        s_w_ready,
    output logic [1:0]               s_b_resp,
    output logic [NUM_CH-1:0]        s_b_valid,
    input  logic [NUM_CH-1:0]        s_b_ready,
    output logic [ADDR_W-1:0]        m_ar_addr,
    output logic                     m_ar_valid,
    input  logic                     m_ar_ready,
    input  logic [DATA_W-1:0]        m_r_data,
    input  logic [1:0]               m_r_resp,
    input  logic                     m_r_valid,
    output logic                     m_r_ready,
    output logic [ADDR_W-1:0]        m_aw_addr,
    output logic                     m_aw_valid,
    input  logic                     m_aw_ready,
    output logic [DATA_W-1:0]        m_w_data,
    output logic [STRB_W-1:0]        m_w_strb,
    output logic                     m_w_valid,
    input  logic                     m_w_ready,
    input  logic [1:0]               m_b_resp,
    input  logic                     m_b_valid,
    output logic                     m_b_ready
);

    localparam int IDX_W = $clog2(NUM_CH);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    g_q, g_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [IDX_W-1:0]    arb_ptr;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   gnt_oh;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;

`ifdef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    ptr_next;
    assign arb_ptr  = ptr_q;
    assign ptr_next = (g_q == IDX_W'(NUM_CH - 1)) ? '0 : g_q + IDX_W'(1);
`endif

    // A write only counts as a request once both address and data are offered.
    assign req = s_ar_valid | (s_aw_valid & s_w_valid);

    ysyx_22051013_rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arb (
        .req     (req),
        .ptr     (arb_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign m_ar_addr  = addr_q;
    assign m_aw_addr  = addr_q;
    assign m_w_data   = w_data_q;
    assign m_w_strb   = w_strb_q;
    assign m_ar_valid = (state_q == ST_RD_ADDR);
    assign m_aw_valid = (state_q == ST_WR_ADDR) && !aw_done_q;
    assign m_w_valid  = (state_q == ST_WR_ADDR) && !w_done_q;
    assign s_r_data   = m_r_data;
    assign s_r_resp   = m_r_resp;
    assign s_b_resp   = m_b_resp;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        addr_d     = addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
`ifndef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        s_ar_ready = '0;
        s_aw_ready = '0;
        s_w_ready  = '0;
        s_r_valid  = '0;
        s_b_valid  = '0;
        m_r_ready  = 1'b0;
        m_b_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rst gating keeps the ready pulses quiet while reset is held.
                if (rst && gnt_any) begin
                    g_d       = gnt_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (s_ar_valid[gnt_idx]) begin
                        s_ar_ready = gnt_oh;
                        addr_d     = s_ar_addr[gnt_idx*ADDR_W +: ADDR_W];
                        state_d    = ST_RD_ADDR;
                    end else begin
                        s_aw_ready = gnt_oh;
                        s_w_ready  = gnt_oh;
                        addr_d     = s_aw_addr[gnt_idx*ADDR_W +: ADDR_W];
                        w_data_d   = s_w_data[gnt_idx*DATA_W +: DATA_W];
                        w_strb_d   = s_w_strb[gnt_idx*STRB_W +: STRB_W];
                        state_d    = ST_WR_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (m_ar_ready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                s_r_valid[g_q] = m_r_valid;
                m_r_ready      = s_r_ready[g_q];
                if (m_r_valid && s_r_ready[g_q]) begin
`ifndef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
                    ptr_d = ptr_next;
`endif
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                aw_done_d = aw_done_q | m_aw_ready;
                w_done_d  = w_done_q | m_w_ready;
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                s_b_valid[g_q] = m_b_valid;
                m_b_ready      = s_b_ready[g_q];
                if (m_b_valid && s_b_ready[g_q]) begin
`ifndef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
                    ptr_d = ptr_next;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            addr_q    <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            addr_q    <= addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifndef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_axi_arb.sv
// Directed bench for ysyx_22051013_axi_arb: reads, writes, arbitration order,
// backpressure, error responses and asynchronous reset mid-transaction.
module tb_ysyx_22051013_axi_arb;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*ADDR_W-1:0] s_ar_addr;
    logic [NUM_CH-1:0]        s_ar_valid;
    logic [NUM_CH-1:0]        s_ar_ready;
    logic [DATA_W-1:0]        s_r_data;
    logic [1:0]               s_r_resp;
    logic [NUM_CH-1:0]        s_r_valid;
    logic [NUM_CH-1:0]        s_r_ready;
    logic [NUM_CH*ADDR_W-1:0] s_aw_addr;
    logic [NUM_CH-1:0]        s_aw_valid;
    logic [NUM_CH-1:0]        s_aw_ready;
    logic [NUM_CH*DATA_W-1:0] s_w_data;
    logic [NUM_CH*STRB_W-1:0] s_w_strb;
    logic [NUM_CH-1:0]        s_w_valid;
    logic [NUM_CH-1:0]        s_w_ready;
    logic [1:0]               s_b_resp;
    logic [NUM_CH-1:0]        s_b_valid;
    logic [NUM_CH-1:0]        s_b_ready;
    logic [ADDR_W-1:0]        m_ar_addr;
    logic                     m_ar_valid;
    logic                     m_ar_ready;
    logic [DATA_W-1:0]        m_r_data;
    logic [1:0]               m_r_resp;
    logic                     m_r_valid;
    logic                     m_r_ready;
    logic [ADDR_W-1:0]        m_aw_addr;
    logic                     m_aw_valid;
    logic                     m_aw_ready;
    logic [DATA_W-1:0]        m_w_data;
    logic [STRB_W-1:0]        m_w_strb;
    logic                     m_w_valid;
    logic                     m_w_ready;
    logic [1:0]               m_b_resp;
    logic                     m_b_valid;
    logic                     m_b_ready;

    int total = 0;
    int bad   = 0;

    ysyx_22051013_axi_arb #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_ar_addr  (s_ar_addr),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_r_data   (s_r_data),
        .s_r_resp   (s_r_resp),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .s_aw_addr  (s_aw_addr),
        .s_aw_valid (s_aw_valid),
        .s_aw_ready (s_aw_ready),
        .s_w_data   (s_w_data),
        .s_w_strb   (s_w_strb),
        .s_w_valid  (s_w_valid),
        .s_w_ready  (s_w_ready),
        .s_b_resp   (s_b_resp),
        .s_b_valid  (s_b_valid),
        .s_b_ready  (s_b_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_r_data   (m_r_data),
        .m_r_resp   (m_r_resp),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .m_aw_addr  (m_aw_addr),
        .m_aw_valid (m_aw_valid),
        .m_aw_ready (m_aw_ready),
        .m_w_data   (m_w_data),
        .m_w_strb   (m_w_strb),
        .m_w_valid  (m_w_valid),
        .m_w_ready  (m_w_ready),
        .m_b_resp   (m_b_resp),
        .m_b_valid  (m_b_valid),
        .m_b_ready  (m_b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task applyStimulus;
        @(posedge clk);
        #1;
    endtask

    task settle;
        #1;
    endtask

    // Complete one read from IDLE; s_ar_valid is already set by the caller.
    task readTxn(input int ch, input logic [ADDR_W-1:0] addr_exp,
                 input logic [DATA_W-1:0] rdata, input logic [NUM_CH-1:0] valid_after,
                 input string tag);
        logic [NUM_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        checkOutput({tag, "_ar_ready"}, 64'(s_ar_ready), 64'(oh));
        applyStimulus;
        s_ar_valid = valid_after;
        settle;
        checkOutput({tag, "_m_ar_valid"}, 64'(m_ar_valid), 64'd1);
        checkOutput({tag, "_m_ar_addr"}, 64'(m_ar_addr), 64'(addr_exp));
        m_ar_ready = 1'b1;
        applyStimulus;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        m_r_data   = rdata;
        m_r_resp   = 2'b00;
        s_r_ready  = '1;
        settle;
        checkOutput({tag, "_s_r_valid"}, 64'(s_r_valid), 64'(oh));
        checkOutput({tag, "_s_r_data"}, 64'(s_r_data), 64'(rdata));
        checkOutput({tag, "_m_r_ready"}, 64'(m_r_ready), 64'd1);
        applyStimulus;
        m_r_valid = 1'b0;
        s_r_ready = '0;
        settle;
        checkOutput({tag, "_r_valid_drop"}, 64'(s_r_valid), 64'd0);
    endtask

    initial begin
        int order [4];
        rst        = 1'b0;
        s_ar_addr  = '0;
        s_ar_valid = 2'b11;
        s_r_ready  = '0;
        s_aw_addr  = '0;
        s_aw_valid = '0;
        s_w_data   = '0;
        s_w_strb   = '0;
        s_w_valid  = '0;
        s_b_ready  = '0;
        m_ar_ready = 1'b0;
        m_r_data   = '0;
        m_r_resp   = '0;
        m_r_valid  = 1'b0;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
        m_b_resp   = '0;
        m_b_valid  = 1'b0;

        // Reset state, including no ready while requests are present.
        settle;
        checkOutput("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        checkOutput("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
        checkOutput("rst_m_w_valid", 64'(m_w_valid), 64'd0);
        checkOutput("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
        checkOutput("rst_m_ar_addr", 64'(m_ar_addr), 64'd0);
        applyStimulus;
        applyStimulus;
        rst        = 1'b1;
        s_ar_valid = '0;
        settle;

        // Single read from ch1.
        s_ar_addr[1*ADDR_W +: ADDR_W] = 32'h8000_0010;
        s_ar_valid = 2'b10;
        settle;
        readTxn(1, 32'h8000_0010, 64'hDEAD_BEEF_0000_0001, 2'b00, "rd1");

        // Back-to-back reads from both channels.
        s_ar_addr[0*ADDR_W +: ADDR_W] = 32'h0000_1000;
        s_ar_addr[1*ADDR_W +: ADDR_W] = 32'h0000_2000;
`ifdef YSYX_22051013_AXI_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 0, 1};
`endif
        s_ar_valid = 2'b11;
        settle;
        for (int i = 0; i < 4; i++) begin
            readTxn(order[i], (order[i] == 0) ? 32'h0000_1000 : 32'h0000_2000,
                    64'h1111_0000_0000_0000 + 64'(i), 2'b11, $sformatf("rr%0d", i));
        end
        s_ar_valid = '0;
        settle;

        // ch1 write: data valid arrives three cycles late; slave takes w before aw.
        s_aw_addr[1*ADDR_W +: ADDR_W] = 32'h8000_0100;
        s_w_data[1*DATA_W +: DATA_W]  = 64'h1122_3344_5566_7788;
        s_w_strb[1*STRB_W +: STRB_W]  = 8'hF0;
        s_aw_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle;
            checkOutput($sformatf("wr_wait%0d_aw_ready", i), 64'(s_aw_ready), 64'd0);
            applyStimulus;
        end
        s_w_valid = 2'b10;
        settle;
        checkOutput("wr_aw_ready", 64'(s_aw_ready), 64'h2);
        checkOutput("wr_w_ready", 64'(s_w_ready), 64'h2);
        applyStimulus;
        s_aw_valid = '0;
        s_w_valid  = '0;
        m_w_ready  = 1'b1;
        settle;
        checkOutput("wr_m_aw_valid", 64'(m_aw_valid), 64'd1);
        checkOutput("wr_m_w_valid", 64'(m_w_valid), 64'd1);
        checkOutput("wr_m_aw_addr", 64'(m_aw_addr), 64'h8000_0100);
        checkOutput("wr_m_w_data", 64'(m_w_data), 64'h1122_3344_5566_7788);
        checkOutput("wr_m_w_strb", 64'(m_w_strb), 64'hF0);
        applyStimulus;
        m_w_ready = 1'b0;
        s_b_ready = 2'b11;
        settle;
        checkOutput("wr_w_dropped", 64'(m_w_valid), 64'd0);
        checkOutput("wr_aw_held", 64'(m_aw_valid), 64'd1);
        checkOutput("wr_no_resp_yet", 64'(m_b_ready), 64'd0);
        m_aw_ready = 1'b1;
        applyStimulus;
        m_aw_ready = 1'b0;
        m_b_valid  = 1'b1;
        m_b_resp   = 2'b00;
        settle;
        checkOutput("wr_aw_dropped", 64'(m_aw_valid), 64'd0);
        checkOutput("wr_s_b_valid", 64'(s_b_valid), 64'h2);
        checkOutput("wr_m_b_ready", 64'(m_b_ready), 64'd1);
        checkOutput("wr_s_b_resp", 64'(s_b_resp), 64'd0);
        applyStimulus;
        m_b_valid = 1'b0;
        s_b_ready = '0;
        settle;
        checkOutput("wr_b_valid_drop", 64'(s_b_valid), 64'd0);

        // ch0 read with address and response backpressure while ch1 keeps requesting.
        s_ar_addr[0*ADDR_W +: ADDR_W] = 32'h0000_3000;
        s_ar_valid = 2'b11;
        settle;
        checkOutput("bp_ar_ready", 64'(s_ar_ready), 64'h1);
        applyStimulus;
        s_ar_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            settle;
            checkOutput($sformatf("bp_ar_valid%0d", i), 64'(m_ar_valid), 64'd1);
            checkOutput($sformatf("bp_ar_addr%0d", i), 64'(m_ar_addr), 64'h3000);
            checkOutput($sformatf("bp_no_grant%0d", i), 64'(s_ar_ready), 64'd0);
            applyStimulus;
        end
        m_ar_ready = 1'b1;
        settle;
        checkOutput("bp_ar_valid_last", 64'(m_ar_valid), 64'd1);
        applyStimulus;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        m_r_data   = 64'hCAFE_F00D_0000_0003;
        s_r_ready  = 2'b10;
        for (int i = 0; i < 2; i++) begin
            settle;
            checkOutput($sformatf("bp_s_r_valid%0d", i), 64'(s_r_valid), 64'h1);
            checkOutput($sformatf("bp_m_r_ready%0d", i), 64'(m_r_ready), 64'd0);
            checkOutput($sformatf("bp_r_no_grant%0d", i), 64'(s_ar_ready), 64'd0);
            applyStimulus;
        end
        s_r_ready = 2'b01;
        settle;
        checkOutput("bp_m_r_ready", 64'(m_r_ready), 64'd1);
        checkOutput("bp_s_r_data", 64'(s_r_data), 64'hCAFE_F00D_0000_0003);
        applyStimulus;
        m_r_valid = 1'b0;
        s_r_ready = '0;
        settle;
        checkOutput("bp_next_grant", 64'(s_ar_ready), 64'h2);
        s_ar_valid = '0;
        settle;

        // ch0 write answered with SLVERR, aw and w accepted together.
        s_aw_addr[0*ADDR_W +: ADDR_W] = 32'h0000_4000;
        s_w_data[0*DATA_W +: DATA_W]  = 64'hA5A5_A5A5_5A5A_5A5A;
        s_w_strb[0*STRB_W +: STRB_W]  = 8'h0F;
        s_aw_valid = 2'b01;
        s_w_valid  = 2'b01;
        settle;
        checkOutput("err_aw_ready", 64'(s_aw_ready), 64'h1);
        applyStimulus;
        s_aw_valid = '0;
        s_w_valid  = '0;
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        settle;
        checkOutput("err_m_w_strb", 64'(m_w_strb), 64'h0F);
        applyStimulus;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
        m_b_valid  = 1'b1;
        m_b_resp   = 2'b10;
        s_b_ready  = 2'b01;
        settle;
        checkOutput("err_s_b_valid", 64'(s_b_valid), 64'h1);
        checkOutput("err_s_b_resp", 64'(s_b_resp), 64'h2);
        applyStimulus;
        m_b_valid = 1'b0;
        m_b_resp  = 2'b00;
        s_b_ready = '0;
        settle;

        // Reset during RD_DATA of a ch0 read.
        s_ar_addr[0*ADDR_W +: ADDR_W] = 32'h0000_5000;
        s_ar_valid = 2'b01;
        settle;
        checkOutput("rr_idle_after_err", 64'(s_ar_ready), 64'h1);
        applyStimulus;
        s_ar_valid = '0;
        m_ar_ready = 1'b1;
        applyStimulus;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        s_r_ready  = 2'b00;
        settle;
        checkOutput("mid_s_r_valid", 64'(s_r_valid), 64'h1);
        s_r_ready = 2'b01;
        settle;
        rst = 1'b0;
        settle;
        checkOutput("arst_s_r_valid", 64'(s_r_valid), 64'd0);
        checkOutput("arst_m_r_ready", 64'(m_r_ready), 64'd0);
        checkOutput("arst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        checkOutput("arst_m_ar_addr", 64'(m_ar_addr), 64'd0);
        m_r_valid = 1'b0;
        s_r_ready = '0;
        applyStimulus;
        rst        = 1'b1;
        s_ar_valid = 2'b11;
        settle;
        checkOutput("post_rst_ptr", 64'(s_ar_ready), 64'h1);
        s_ar_valid = 2'b10;
        s_ar_addr[1*ADDR_W +: ADDR_W] = 32'h0000_6000;
        settle;
        readTxn(1, 32'h0000_6000, 64'h0BAD_F00D_0000_0006, 2'b00, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
